// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of the serializer.
// A word is popped into the shift register on the edge its start bit begins.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          start,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BW       = $clog2(DATA_W);
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(STOP_LEN);
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_RELOAD = TW'(STOP_LEN - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     baud, baud_nx;
  logic [BW-1:0]     bit_idx, bit_idx_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              par_bit, par_bit_nx;
  logic              tx_nx;
  logic              pop, push, nonempty, bit_end;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  assign ready    = (fifo_count != CW'(FIFO_DEPTH));
  assign push     = start && ready;
  assign nonempty = (fifo_count != '0);
  assign bit_end  = (baud == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // State register plus FIFO bookkeeping; tx is registered from tx_nx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      par_bit <= par_bit_nx;
      tx      <= tx_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      overflow <= overflow | (start & ~ready);
    end
  end

  always_comb begin
    state_nx   = state;
    baud_nx    = bit_end ? BIT_RELOAD : baud - 1'b1;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    par_bit_nx = par_bit;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_nx = BIT_RELOAD;
        if (nonempty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == BW'(DATA_W - 1)) begin
            if (PARITY != 0) begin
              state_nx = PAR;
            end else begin
              state_nx = STOP;
              baud_nx  = STOP_RELOAD;
            end
          end else begin
            shreg_nx   = shreg >> 1;
            bit_idx_nx = bit_idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_nx = STOP;
          baud_nx  = STOP_RELOAD;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (nonempty) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Loading happens only on a pop, so writes never disturb the frame in flight.
    if (pop) begin
      shreg_nx   = mem[rd_ptr];
      par_bit_nx = (^mem[rd_ptr]) ^ (PARITY == 1);
      bit_idx_nx = '0;
    end
  end

  always_comb begin
    busy = (state != IDLE);
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      PAR:     tx_nx = par_bit_nx;
      default: tx_nx = 1'b1;
    endcase
  end

endmodule
